imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the RV64I decode stage. It accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes all base immediate formats (I, S, B, U, J). Each result is sign-extended to XLEN and held in a 2-entry output buffer, so downstream stalls never drop an instruction. It sits between fetch/decode and the ALU/branch-target operand muxes.

Parameters:
XLEN, 64, output immediate width; legal values 32 or 64.
ILEN, 32, instruction width; fixed at 32.
DEPTH, 2, output buffer entries; legal values 2 or 4 (power of two).

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  instruction on in_inst is valid.
in_ready  out  1  block can accept an instruction this cycle.
in_inst  in  ILEN  raw instruction word.
out_valid  out  1  head buffer entry is valid.
out_ready  in  1  consumer takes the head entry this cycle.
out_imm  out  XLEN  sign-extended immediate of the head entry.
out_fmt  out  3  format of the head entry: 0=NONE, 1=I, 2=S, 3=B, 4=U, 5=J.
out_illegal  out  1  opcode of the head entry is not an immediate-bearing opcode.

Behaviour:
- Reset (rst=1 at an edge):
  - count=0, rd/wr pointers=0, buffer contents cleared.
  - out_valid=0, out_imm=0, out_fmt=0, out_illegal=0, in_ready=1 from the next cycle.
  - Reset mid-operation discards all buffered entries; nothing in flight is emitted.
- Opcode decode on in_inst[6:0]; this decode is combinational ahead of the buffer write:
  - I: 0000011 (load), 0010011 (op-imm), 0011011 (op-imm-32), 1100111 (jalr); imm = inst[31:20].
  - S: 0100011; imm = {inst[31:25], inst[11:7]}.
  - B: 1100011; imm = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}.
  - U: 0110111 (lui), 0010111 (auipc); imm = {inst[31:12], 12'b0}.
  - J: 1101111; imm = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}.
  - Any other opcode: fmt=NONE, imm=0, illegal=1.
  - All immediates are sign-extended from inst[31] to XLEN. For U with XLEN=64, bits 63:32 equal inst[31].
- Push/pop:
  - Push occurs when in_valid && in_ready. Pop occurs when out_valid && out_ready.
  - in_ready = (count < DEPTH). It is derived from registered state only and has no combinational path from out_ready.
  - out_valid = (count != 0). out_imm, out_fmt and out_illegal come from the registered head entry.
- Latency: an instruction accepted at edge t is visible on the outputs from edge t onward if the buffer was empty, i.e. one cycle after presentation. Sustained throughput is 1 per cycle when out_ready=1.
- Boundary conditions:
  - Simultaneous push and pop with 0<count<DEPTH: count unchanged, both pointers advance.
  - Full buffer: in_ready=0, so no push can occur.
  - Empty buffer: a pop is impossible because out_valid=0.
  - Pointers wrap modulo DEPTH.
  - Output order always equals acceptance order.
  - While out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal stay stable.

Optional Feature:
- Macro IMM_ERR_CNT_EN.
- Defined: adds output port err_cnt (16 bits), a count of accepted instructions with illegal=1.
  - Counts at push time, saturates at 0xFFFF, cleared by rst.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package imm_pkg holds:
  - typedef enum logic [2:0] imm_fmt_t {FMT_NONE, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}.
  - The opcode localparams OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL.
  - A packed struct imm_entry_t {imm, fmt, illegal}.
- Sub-module imm_decode: purely combinational in_inst -> imm_entry_t, reusable by other decode paths.
- The buffer and handshake logic live in imm_gen_pipe.

Test Plan:
- ld x1,-8(x2): push 0xFF813083, out_ready=1 -> out_imm=0xFFFFFFFFFFFFFFF8, fmt=I, illegal=0, one cycle later.
- sd x1,16(x2): 0x00113823 -> out_imm=0x0000000000000010, fmt=S; then beq -4: 0xFE000EE3 -> 0xFFFFFFFFFFFFFFFC, fmt=B, emitted back-to-back.
- lui 0x12345: 0x123452B7 -> out_imm=0x0000000012345000, fmt=U; lui 0x80000: 0x800002B7 -> 0xFFFFFFFF80000000.
- add x1,x2,x3: 0x003100B3 -> out_imm=0, fmt=NONE, illegal=1; with IMM_ERR_CNT_EN defined, err_cnt goes 0 -> 1.
- Backpressure: out_ready=0, in_valid=1 for 3 instructions -> exactly 2 accepted and in_ready=0; raise out_ready -> outputs emerge in order, then the third is accepted with no loss or duplication.
- Reset mid-operation: buffer full, assert rst for 1 cycle -> out_valid=0, out_imm=0, in_ready=1; no stale entries appear afterwards.

Source files
------------

// File: rtl/imm_gen_pipe_pkg.sv
// Package imm_pkg: shared types and constants for the immediate generator.
//   imm_fmt_t   - immediate format code driven on out_fmt
//   OPC_*       - RV64I opcodes that carry an immediate
//   imm_entry_t - one decoded result as stored in the output buffer
// The stored immediate is always IMM_MAX_W (64) bits wide and already
// sign-extended, so a 32-bit consumer simply keeps the low half.
package imm_pkg;

    localparam int IMM_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_t;

    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;

    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        imm_fmt_t             fmt;
        logic                 illegal;
    } imm_entry_t;

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// imm_decode: purely combinational RV64I immediate decoder.
//   inst  in  32  raw instruction word
//   entry out     decoded {imm (sign-extended to 64), fmt, illegal}
// Opcodes without an immediate yield imm=0, fmt=FMT_NONE, illegal=1.
module imm_decode
    import imm_pkg::*;
(
    input  logic [31:0] inst,
    output imm_entry_t  entry
);

    logic s;
    assign s = inst[31];

    always_comb begin
        entry         = '0;
        entry.fmt     = FMT_NONE;
        entry.illegal = 1'b0;
        case (inst[6:0])
            OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: begin
                entry.fmt = FMT_I;
                entry.imm = {{52{s}}, inst[31:20]};
            end
            OPC_STORE: begin
                entry.fmt = FMT_S;
                entry.imm = {{52{s}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                entry.fmt = FMT_B;
                entry.imm = {{51{s}}, s, inst[7], inst[30:25], inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                entry.fmt = FMT_U;
                entry.imm = {{32{s}}, inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                entry.fmt = FMT_J;
                entry.imm = {{43{s}}, s, inst[19:12], inst[20], inst[30:21], 1'b0};
            end
            default: begin
                entry.fmt     = FMT_NONE;
                entry.imm     = '0;
                entry.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined immediate generator with a DEPTH-entry output buffer.
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  input handshake, in_inst = instruction word
//   out_valid/out_ready output handshake for the head buffer entry
//   out_imm/out_fmt/out_illegal  decoded head entry (zero while empty)
//   err_cnt            (only with IMM_ERR_CNT_EN) saturating count of
//                      accepted instructions flagged illegal
// Parameters: XLEN 32|64, ILEN fixed 32, DEPTH 2|4.
// Optional build macro: IMM_ERR_CNT_EN.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [ILEN-1:0] in_inst,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal
`ifdef IMM_ERR_CNT_EN
    ,
    output logic [15:0]     err_cnt
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    imm_entry_t       dec_entry;
    imm_entry_t       buf_reg [DEPTH];
    imm_entry_t       head;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             push;
    logic             pop;

    imm_decode u_decode (
        .inst  (in_inst[31:0]),
        .entry (dec_entry)
    );

    // Both handshake flags depend on count_reg only, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (count_reg < CNT_W'(DEPTH));
    assign out_valid = (count_reg != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            count_reg <= count_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    buf_reg[gi] <= '0;
                end else if (push && (wr_ptr_reg == PTR_W'(gi))) begin
                    buf_reg[gi] <= dec_entry;
                end
            end
        end
    endgenerate

    // Head is read from registered storage; masked to zero while empty so
    // drained slots never leak stale data onto the outputs.
    always_comb begin
        head = buf_reg[rd_ptr_reg];
        if (!out_valid) head = '0;
    end

    assign out_imm     = head.imm[XLEN-1:0];
    assign out_fmt     = head.fmt;
    assign out_illegal = head.illegal;

`ifdef IMM_ERR_CNT_EN
    logic [15:0] err_cnt_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (push && dec_entry.illegal && (err_cnt_reg != 16'hFFFF)) begin
            err_cnt_reg <= err_cnt_reg + 16'd1;
        end
    end

    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed self-checking bench for imm_gen_pipe (XLEN=64, DEPTH=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_imm_gen_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
`ifdef IMM_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int checks;
    int failures;

    imm_gen_pipe #(.XLEN(64), .ILEN(32), .DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_imm     (out_imm),
        .out_fmt     (out_fmt),
        .out_illegal (out_illegal)
`ifdef IMM_ERR_CNT_EN
        ,
        .err_cnt     (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s got=%h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check full head entry: valid, imm, fmt, illegal.
    task automatic check_head(input string tag, input logic [63:0] imm,
                              input logic [2:0] fmt, input logic ill);
        check({tag, ".valid"},   64'(out_valid),   64'd1);
        check({tag, ".imm"},     out_imm,          imm);
        check({tag, ".fmt"},     64'(out_fmt),     64'(fmt));
        check({tag, ".illegal"}, 64'(out_illegal), 64'(ill));
    endtask

    // Directed single-instruction vectors, each pushed then popped.
    typedef struct {
        logic [31:0] inst;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    vec_t vecs[6];

    initial begin
        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = 32'h0;
        out_ready = 1'b0;

        vecs[0] = '{32'h0080006F, 64'h0000000000000008, 3'd5, 1'b0}; // jal +8
        vecs[1] = '{32'hFFDFF06F, 64'hFFFFFFFFFFFFFFFC, 3'd5, 1'b0}; // jal -4
        vecs[2] = '{32'h00001297, 64'h0000000000001000, 3'd4, 1'b0}; // auipc 1
        vecs[3] = '{32'h00008067, 64'h0000000000000000, 3'd1, 1'b0}; // jalr ret
        vecs[4] = '{32'h123452B7, 64'h0000000012345000, 3'd4, 1'b0}; // lui
        vecs[5] = '{32'h800002B7, 64'hFFFFFFFF80000000, 3'd4, 1'b0}; // lui neg

        step();
        step();
        rst = 1'b0;
        check("rst.valid",   64'(out_valid),   64'd0);
        check("rst.imm",     out_imm,          64'd0);
        check("rst.fmt",     64'(out_fmt),     64'd0);
        check("rst.illegal", 64'(out_illegal), 64'd0);
        check("rst.ready",   64'(in_ready),    64'd1);
`ifdef IMM_ERR_CNT_EN
        check("rst.errcnt",  64'(err_cnt),     64'd0);
`endif

        // ld x1,-8(x2) with out_ready=1: visible after the accepting edge.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_inst   = 32'hFF813083;
        step();
        in_valid = 1'b0;
        check_head("ld", 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b0);
        step();
        check("ld.drain", 64'(out_valid), 64'd0);

        // sd then beq back-to-back.
        in_valid = 1'b1;
        in_inst  = 32'h00113823;
        step();
        check_head("sd", 64'h0000000000000010, 3'd2, 1'b0);
        in_inst = 32'hFE000EE3;
        step();
        in_valid = 1'b0;
        check_head("beq", 64'hFFFFFFFFFFFFFFFC, 3'd3, 1'b0);
        step();
        check("beq.drain", 64'(out_valid), 64'd0);

        // Table vectors.
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_inst  = vecs[i].inst;
            step();
            in_valid = 1'b0;
            check_head($sformatf("vec%0d", i), vecs[i].imm, vecs[i].fmt, vecs[i].ill);
            step();
        end

        // add: no immediate -> illegal.
        in_valid = 1'b1;
        in_inst  = 32'h003100B3;
        step();
        in_valid = 1'b0;
        check_head("add", 64'd0, 3'd0, 1'b1);
`ifdef IMM_ERR_CNT_EN
        check("add.errcnt", 64'(err_cnt), 64'd1);
`endif
        step();

        // Backpressure: three offered, two accepted, then drain in order.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'hFF813083; // A: ld -8
        step();
        check("bp.ready1", 64'(in_ready), 64'd1);
        in_inst = 32'h00113823;   // B: sd 16
        step();
        check("bp.ready2", 64'(in_ready), 64'd0);
        in_inst = 32'h123452B7;   // C: lui (must wait)
        step();
        check("bp.ready3", 64'(in_ready), 64'd0);
        check_head("bp.holdA", 64'hFFFFFFFFFFFFFFF8, 3'd1, 1'b0);
        out_ready = 1'b1;
        step();
        check_head("bp.B", 64'h0000000000000010, 3'd2, 1'b0);
        step();
        in_valid = 1'b0;
        check_head("bp.C", 64'h0000000012345000, 3'd4, 1'b0);
        step();
        check("bp.drain", 64'(out_valid), 64'd0);

        // Reset while full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_inst   = 32'h003100B3;
        step();
        in_inst = 32'h800002B7;
        step();
        in_valid = 1'b0;
        check("mr.full", 64'(in_ready), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mr.valid", 64'(out_valid), 64'd0);
        check("mr.imm",   out_imm,        64'd0);
        check("mr.ready", 64'(in_ready),  64'd1);
`ifdef IMM_ERR_CNT_EN
        check("mr.errcnt", 64'(err_cnt),  64'd0);
`endif
        out_ready = 1'b1;
        step();
        step();
        check("mr.nostale", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
